// File: rtl/mux_pkg.sv
// Shared types and defaults for the N:1 registered word selector.
package mux_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_NUM_IN = 4;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_t;

    // Entry layout at the default width: error flag above the data word.
    typedef struct packed {
        logic                 err;
        logic [DEF_WIDTH-1:0] data;
    } mux_entry_t;

endpackage

// File: rtl/skid_buf.sv
// Two-entry valid/ready skid buffer: main (output) register plus skid register,
// with in_ready taken straight from a flop.
module skid_buf
    import mux_pkg::*;
#(
    parameter int DW = 33
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic [1:0]    occupancy
);

    occ_state_t    state_reg, state_next;
    logic [DW-1:0] main_reg, main_next;
    logic [DW-1:0] skid_reg, skid_next;
    logic          in_ready_reg;
    logic          accept;
    logic          drain;

    assign accept    = in_valid && in_ready_reg;
    assign drain     = out_valid && out_ready;
    assign in_ready  = in_ready_reg;
    assign out_valid = (state_reg != EMPTY);
    assign out_data  = main_reg;
    assign occupancy = state_reg;

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        case (state_reg)
            EMPTY: begin
                if (accept) begin
                    main_next  = in_data;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (accept && !drain) begin
                    skid_next  = in_data;
                    state_next = FULL;
                end else if (accept && drain) begin
                    main_next  = in_data;
                end else if (drain) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only a drain can happen.
                if (drain) begin
                    main_next  = skid_reg;
                    state_next = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= EMPTY;
            main_reg     <= '0;
            skid_reg     <= '0;
            in_ready_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            main_reg     <= main_next;
            skid_reg     <= skid_next;
            in_ready_reg <= (state_next != FULL);
        end
    end

endmodule

// File: rtl/mux_nx1_pipe.sv
// NUM_IN:1 word selector with out-of-range flag, registered behind a skid buffer.
module mux_nx1_pipe
    import mux_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int NUM_IN = DEF_NUM_IN,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_sel_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [1:0]              occupancy
);

    localparam int              NUM_CODES = 1 << SEL_W;
    localparam logic [SEL_W:0]  NUM_IN_L  = (SEL_W + 1)'(NUM_IN);

    typedef struct packed {
        logic             err;
        logic [WIDTH-1:0] data;
    } entry_t;

    logic [WIDTH-1:0] word_arr [NUM_CODES];
    logic             sel_err;
    entry_t           entry_in;
    entry_t           entry_out;

    // Unused select codes read as zero, so out-of-range data is 0 without an extra mux.
    generate
        for (genvar gi = 0; gi < NUM_CODES; gi++) begin : g_word
            if (gi < NUM_IN) begin : g_used
                assign word_arr[gi] = in_data[gi*WIDTH +: WIDTH];
            end else begin : g_unused
                assign word_arr[gi] = '0;
            end
        end
    endgenerate

    assign sel_err  = ({1'b0, sel} >= NUM_IN_L);
    assign entry_in = '{err: sel_err, data: word_arr[sel]};

    skid_buf #(
        .DW(WIDTH + 1)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (entry_in),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (entry_out),
        .out_ready (out_ready),
        .occupancy (occupancy)
    );

    assign out_data    = entry_out.data;
    assign out_sel_err = entry_out.err;

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Scoreboard bench for mux_nx1_pipe: directed cases, reset, and randomised handshakes.
module tb_mux_nx1_pipe;
    import mux_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // NUM_IN=4 instance
    logic [127:0] in_data;
    logic [1:0]   sel;
    logic         in_valid, in_ready, out_sel_err, out_valid, out_ready;
    logic [31:0]  out_data;
    logic [1:0]   occupancy;

    // NUM_IN=3 instance
    logic [95:0]  in_data3;
    logic [1:0]   sel3;
    logic         in_valid3, in_ready3, out_sel_err3, out_valid3, out_ready3;
    logic [31:0]  out_data3;
    logic [1:0]   occupancy3;

    mux_nx1_pipe #(.WIDTH(32), .NUM_IN(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
        .out_sel_err(out_sel_err), .out_valid(out_valid),
        .out_ready(out_ready), .occupancy(occupancy)
    );

    mux_nx1_pipe #(.WIDTH(32), .NUM_IN(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .sel(sel3),
        .in_valid(in_valid3), .in_ready(in_ready3), .out_data(out_data3),
        .out_sel_err(out_sel_err3), .out_valid(out_valid3),
        .out_ready(out_ready3), .occupancy(occupancy3)
    );

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_acc = 0;
    int          n_drn = 0;
    mux_entry_t  sbq[$];
    logic        hold_pending = 1'b0;
    logic [32:0] held_val = '0;
    logic [127:0] dvec;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic mux_entry_t model(input logic [127:0] d, input logic [1:0] s, input int n);
        mux_entry_t e;
        if (int'(s) >= n) begin
            e.err  = 1'b1;
            e.data = '0;
        end else begin
            e.err  = 1'b0;
            e.data = d[int'(s)*32 +: 32];
        end
        return e;
    endfunction

    // Drive one cycle of inputs at negedge, then score the handshakes the next posedge will take.
    task automatic drive(input logic v, input logic [1:0] s, input logic [127:0] d, input logic r);
        mux_entry_t e;
        @(negedge clk);
        in_valid = v; sel = s; in_data = d; out_ready = r;
        #1;
        if (hold_pending && out_valid)
            check("hold_stable", {31'b0, out_sel_err, out_data}, {31'b0, held_val});
        hold_pending = out_valid && !out_ready;
        held_val     = {out_sel_err, out_data};
        if (out_valid && out_ready) begin
            check("sb_nonempty", 64'(sbq.size() > 0), 64'(1));
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("sb_data", 64'(out_data), 64'(e.data));
                check("sb_err", 64'(out_sel_err), 64'(e.err));
                n_drn++;
                $display("txn %0d out data=%h err=%b", n_drn, out_data, out_sel_err);
            end
        end
        if (in_valid && in_ready) begin
            sbq.push_back(model(d, s, 4));
            n_acc++;
        end
    endtask

    initial begin
        int acc0, drn0, cyc;
        in_valid = 0; sel = 0; in_data = '0; out_ready = 0;
        in_valid3 = 0; sel3 = 0; in_data3 = '0; out_ready3 = 0;
        dvec = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_occ", 64'(occupancy), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_err", 64'(out_sel_err), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Single beat, sel=2
        drive(1, 2'd2, dvec, 1);
        drive(0, 2'd0, dvec, 1);
        check("t1_valid", 64'(out_valid), 64'(1));
        check("t1_data", 64'(out_data), 64'(32'hCCCC_0002));
        check("t1_err", 64'(out_sel_err), 64'(0));
        check("t1_occ", 64'(occupancy), 64'(1));
        drive(0, 2'd0, dvec, 1);
        check("t1_empty", 64'(out_valid), 64'(0));

        // Back-to-back stream
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'(i), dvec, 1);
            check("t2_in_ready", 64'(in_ready), 64'(1));
            if (i > 0) check("t2_data", 64'(out_data), 64'(32'hAAAA_0000 + 32'(i - 1) * 32'h1111_0001));
        end
        drive(0, 2'd0, dvec, 1);
        check("t2_last", 64'(out_data), 64'(32'hDDDD_0003));
        drive(0, 2'd0, dvec, 1);
        check("t2_empty", 64'(occupancy), 64'(0));

        // Backpressure fills the skid entry
        drive(1, 2'd1, dvec, 0);
        drive(1, 2'd2, dvec, 0);
        drive(1, 2'd3, dvec, 0);
        check("t3_in_ready", 64'(in_ready), 64'(0));
        check("t3_occ", 64'(occupancy), 64'(2));
        check("t3_hold", 64'(out_data), 64'(32'hBBBB_0001));
        drive(0, 2'd0, dvec, 0);
        check("t3_still_full", 64'(occupancy), 64'(2));
        drive(0, 2'd0, dvec, 1);
        drive(0, 2'd0, dvec, 1);
        check("t3_second", 64'(out_data), 64'(32'hCCCC_0002));
        check("t3_ready_back", 64'(in_ready), 64'(1));
        drive(0, 2'd0, dvec, 0);
        check("t3_empty", 64'(occupancy), 64'(0));

        // NUM_IN=3: code 3 is out of range
        @(negedge clk);
        in_data3 = dvec[95:0]; sel3 = 2'd3; in_valid3 = 1; out_ready3 = 1;
        @(negedge clk);
        sel3 = 2'd0;
        #1;
        check("t4_err_data", 64'(out_data3), 64'(0));
        check("t4_err_flag", 64'(out_sel_err3), 64'(1));
        check("t4_err_valid", 64'(out_valid3), 64'(1));
        @(negedge clk);
        in_valid3 = 0;
        #1;
        check("t4_ok_flag", 64'(out_sel_err3), 64'(0));
        check("t4_ok_data", 64'(out_data3), 64'(32'hAAAA_0000));

        // Asynchronous reset while full
        drive(1, 2'd0, dvec, 0);
        drive(1, 2'd1, dvec, 0);
        drive(0, 2'd0, dvec, 0);
        check("t5_full", 64'(occupancy), 64'(2));
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_valid", 64'(out_valid), 64'(0));
        check("t5_occ", 64'(occupancy), 64'(0));
        check("t5_data", 64'(out_data), 64'(0));
        check("t5_in_ready", 64'(in_ready), 64'(1));
        sbq.delete();
        hold_pending = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised handshakes
        acc0 = n_acc;
        drn0 = n_drn;
        cyc = 0;
        while ((n_acc - acc0) < 1000 && cyc < 20000) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  {$urandom(), $urandom(), $urandom(), $urandom()}, 1'($urandom_range(0, 1)));
            cyc++;
        end
        for (int k = 0; k < 20 && sbq.size() > 0; k++) drive(0, 2'd0, dvec, 1);
        check("rand_accepted", 64'(n_acc - acc0), 64'(1000));
        check("rand_drained", 64'(n_drn - drn0), 64'(1000));
        check("rand_sb_empty", 64'(sbq.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
